tdm_demux: RTL and testbench

Time-division demultiplexer: the receiving end of the multiplexed data path. A framed word stream carries `NCH` channel samples per frame, one per slot, and `fsync` marks slot 0. The block locks onto frame sync, collects one frame of slots into shadow registers, and publishes all channels at once with a one-cycle `frame_valid` strobe. It flags and recovers from sync loss.

---
 rtl/tdm_demux_if.sv | 42 ++++
 rtl/tdm_demux.sv | 148 ++++++++++++++
 tb/tb_tdm_demux.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - framed sample stream in, published frame out
// Purpose: groups the tdm_demux data path into one bundle.
//   master: drives din/din_valid/fsync (and din_par), observes the frame outputs
//   slave : the demux side, consumes the stream and drives the frame outputs
// Optional feature macro: TDM_DEMUX_PARITY_EN adds din_par and par_err.
interface tdm_demux_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  localparam int SW = $clog2(NCH);

  logic [W-1:0]     din;
  logic             din_valid;
  logic             fsync;
  logic [NCH*W-1:0] ch_data;
  logic             frame_valid;
  logic [SW-1:0]    slot;
  logic             locked;
  logic             sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic             din_par;
  logic             par_err;

  modport master (
    output din, din_valid, fsync, din_par,
    input  ch_data, frame_valid, slot, locked, sync_err, par_err
  );
  modport slave (
    input  din, din_valid, fsync, din_par,
    output ch_data, frame_valid, slot, locked, sync_err, par_err
  );
`else
  modport master (
    output din, din_valid, fsync,
    input  ch_data, frame_valid, slot, locked, sync_err
  );
  modport slave (
    input  din, din_valid, fsync,
    output ch_data, frame_valid, slot, locked, sync_err
  );
`endif
endinterface

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - time-division demultiplexer with frame-sync lock
// Purpose: locks onto fsync, gathers NCH slots into shadow registers and
// publishes the whole frame at once with a one-cycle frame_valid strobe.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   bus (slave) din/din_valid/fsync[/din_par] in;
//               ch_data/frame_valid/slot/locked/sync_err[/par_err] out
// Optional feature macro: TDM_DEMUX_PARITY_EN (per-word even parity check,
// frames containing a bad word are dropped and flagged on par_err).
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);
  localparam int            SW   = $clog2(NCH);
  localparam logic [SW-1:0] LAST = SW'(NCH - 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  // Last slot goes straight to ch_data, so only NCH-1 shadow words are kept.
  logic [W-1:0]     shadow_q [NCH-1];
  logic [W-1:0]     shadow_d [NCH-1];
  logic [NCH*W-1:0] ch_data_q, ch_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             publish;
`ifdef TDM_DEMUX_PARITY_EN
  logic             par_err_q, par_err_d;
  logic             bad_q, bad_d;
  logic             word_bad;

  assign word_bad = ^{bus.din, bus.din_par};
`endif

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    publish       = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_err_d     = 1'b0;
    bad_d         = bad_q;
`endif

    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            shadow_d[0] = bus.din;
            slot_d      = SW'(1);
            state_d     = LOCK;
`ifdef TDM_DEMUX_PARITY_EN
            bad_d       = word_bad;
`endif
          end
        end
        LOCK: begin
          if (bus.fsync) begin
            // Normal frame start at slot 0, early sync elsewhere: either way
            // this word opens a fresh frame and any partial frame is dropped.
            sync_err_d  = (slot_q != '0);
            shadow_d[0] = bus.din;
            slot_d      = SW'(1);
`ifdef TDM_DEMUX_PARITY_EN
            bad_d       = word_bad;
`endif
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else if (slot_q == LAST) begin
            slot_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
            if (bad_q || word_bad) begin
              par_err_d = 1'b1;
            end else begin
              publish = 1'b1;
            end
            bad_d = 1'b0;
`else
            publish = 1'b1;
`endif
          end else begin
            for (int k = 1; k < NCH - 1; k++) begin
              if (slot_q == SW'(k)) shadow_d[k] = bus.din;
            end
            slot_d = slot_q + SW'(1);
`ifdef TDM_DEMUX_PARITY_EN
            bad_d  = bad_q | word_bad;
`endif
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (publish) begin
      for (int k = 0; k < NCH - 1; k++) begin
        ch_data_d[k*W +: W] = shadow_q[k];
      end
      ch_data_d[(NCH-1)*W +: W] = bus.din;
      frame_valid_d             = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int k = 0; k < NCH - 1; k++) shadow_q[k] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q     <= 1'b0;
      bad_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      for (int k = 0; k < NCH - 1; k++) shadow_q[k] <= shadow_d[k];
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q     <= par_err_d;
      bad_q         <= bad_d;
`endif
    end
  end

  assign bus.ch_data     = ch_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = (state_q == LOCK);
  assign bus.sync_err    = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err     = par_err_q;
`endif
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - table-driven and scoreboard bench for tdm_demux
module tb_tdm_demux;
  localparam int NCH = 4;
  localparam int W   = 8;

  typedef struct {
    logic        v;
    logic        fs;
    logic [7:0]  d;
    logic        el;
    logic [1:0]  es;
    logic        ese;
    logic        efv;
    logic [31:0] ech;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] cur_ch = '0;
  logic [31:0] sb [$];
  vec_t tbl [$];
`ifdef TDM_DEMUX_PARITY_EN
  logic flip_par = 1'b0;
`endif

  tdm_demux_if #(.NCH(NCH), .W(W)) bus ();

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic v, logic fs, logic [7:0] d, logic el,
                              logic [1:0] es, logic ese, logic efv, logic [31:0] ech);
    vec_t r;
    r.v = v; r.fs = fs; r.d = d; r.el = el;
    r.es = es; r.ese = ese; r.efv = efv; r.ech = ech;
    return r;
  endfunction

  // Drive one cycle of stimulus, then check the registered outputs after the edge.
  task automatic run_row(input vec_t r, input string tag);
    bus.din       = r.d;
    bus.din_valid = r.v;
    bus.fsync     = r.fs;
`ifdef TDM_DEMUX_PARITY_EN
    bus.din_par   = (^r.d) ^ flip_par;
`endif
    if (r.efv) begin
      sb.push_back(r.ech);
      cur_ch = r.ech;
    end
    @(posedge clk);
    #1;
    chk({tag, ".locked"},      32'(bus.locked),      32'(r.el));
    chk({tag, ".slot"},        32'(bus.slot),        32'(r.es));
    chk({tag, ".sync_err"},    32'(bus.sync_err),    32'(r.ese));
    chk({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(r.efv));
    chk({tag, ".ch_data"},     bus.ch_data,          cur_ch);
  endtask

  // Scoreboard: every published frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && bus.frame_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got frame %h expected none", bus.ch_data);
      end else begin
        chk("sb_frame", bus.ch_data, sb.pop_front());
      end
    end
  end

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.fsync     = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    bus.din_par   = 1'b0;
`endif

    // Idle words in HUNT, fsync without valid, first frame.
    tbl.push_back(mk(1, 0, 8'hAA, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hBB, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hCC, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h01, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h02, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h03, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h04, 1, 0, 0, 1, 32'h04030201));
    // Frame with 3-cycle gaps between words (one gap carries a stray fsync).
    tbl.push_back(mk(1, 1, 8'h05, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h06, 1, 2, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 8'h00, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h07, 1, 3, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 8'h00, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h08, 1, 0, 0, 1, 32'h08070605));
    // Early sync at slot 2, then the restarted frame completes.
    tbl.push_back(mk(1, 1, 8'hA1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hA2, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h10, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'hB2, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hB3, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hB4, 1, 0, 0, 1, 32'hB4B3B210));
    // Back-to-back frames: frame_valid every NCH cycles.
    tbl.push_back(mk(1, 1, 8'hC1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hC2, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hC3, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hC4, 1, 0, 0, 1, 32'hC4C3C2C1));
    tbl.push_back(mk(1, 1, 8'hD1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hD2, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hD3, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hD4, 1, 0, 0, 1, 32'hD4D3D2D1));
    // Missing sync: error, drop to HUNT, later words ignored.
    tbl.push_back(mk(1, 0, 8'h99, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'hAA, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ch_data",     bus.ch_data,              32'h0);
    chk("rst.frame_valid", 32'(bus.frame_valid),     32'h0);
    chk("rst.slot",        32'(bus.slot),            32'h0);
    chk("rst.locked",      32'(bus.locked),          32'h0);
    chk("rst.sync_err",    32'(bus.sync_err),        32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_row(tbl[i], $sformatf("row%0d", i));
    end

    // Mid-frame asynchronous reset after slot 2.
    run_row(mk(1, 1, 8'h51, 1, 1, 0, 0, 0), "mr0");
    run_row(mk(1, 0, 8'h52, 1, 2, 0, 0, 0), "mr1");
    run_row(mk(1, 0, 8'h53, 1, 3, 0, 0, 0), "mr2");
    #2 rst = 1'b1;
    #1;
    cur_ch = '0;
    chk("mrst.ch_data",     bus.ch_data,          32'h0);
    chk("mrst.frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("mrst.slot",        32'(bus.slot),        32'h0);
    chk("mrst.locked",      32'(bus.locked),      32'h0);
    chk("mrst.sync_err",    32'(bus.sync_err),    32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    // Last slot of the lost frame: no fsync, so it must not relock.
    run_row(mk(1, 0, 8'h54, 0, 0, 0, 0, 0), "mr3");
`ifdef TDM_DEMUX_PARITY_EN
    run_row(mk(1, 1, 8'h61, 1, 1, 0, 0, 0), "pe0");
    flip_par = 1'b1;
    run_row(mk(1, 0, 8'h62, 1, 2, 0, 0, 0), "pe1");
    flip_par = 1'b0;
    run_row(mk(1, 0, 8'h63, 1, 3, 0, 0, 0), "pe2");
    run_row(mk(1, 0, 8'h64, 1, 0, 0, 0, 0), "pe3");
    chk("pe3.par_err", 32'(bus.par_err), 32'h1);
    run_row(mk(0, 0, 8'h00, 1, 0, 0, 0, 0), "pe4");
    chk("pe4.par_err", 32'(bus.par_err), 32'h0);
`endif
    run_row(mk(1, 1, 8'h11, 1, 1, 0, 0, 0), "rf0");
    run_row(mk(1, 0, 8'h22, 1, 2, 0, 0, 0), "rf1");
    run_row(mk(1, 0, 8'h33, 1, 3, 0, 0, 0), "rf2");
    run_row(mk(1, 0, 8'h44, 1, 0, 0, 1, 32'h44332211), "rf3");
    run_row(mk(0, 0, 8'h00, 1, 0, 0, 0, 0), "rf4");

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
